mem_arbiter: RTL

- Shares one single-port 4K x 32 memory between the instruction-fetch port and the data-access port of the multi-cycle core.
- Sits between the core's IM/DM strobes and the memory macro. Serialises requests, applies fixed-latency read timing, and returns a one-cycle ack per request.
- DM has priority by default. A starvation limiter guarantees IM progress.

---
 rtl/mem_arbiter.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port 4K x 32 memory between the instruction-fetch (IM)
// and data-access (DM) ports, with DM priority and a starvation limiter for IM.
module mem_arbiter #(
    parameter int          MEM_LATENCY  = 1,
    parameter logic [11:0] IM_BASE      = 12'hC00,
    parameter int          STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        im_req,
    input  logic [9:0]  im_address,
    output logic        im_ack,
    output logic [31:0] im_rdata,
    input  logic        dm_read,
    input  logic        dm_write,
    input  logic [11:0] dm_address,
    input  logic [31:0] dm_wdata,
    output logic        dm_ack,
    output logic [31:0] dm_rdata,
    output logic        mem_enable,
    output logic        mem_read,
    output logic        mem_write,
    output logic [11:0] mem_address,
    output logic [31:0] mem_in,
    input  logic [31:0] mem_out,
    output logic        busy,
    output logic        grant_dm,
    output logic        protocol_error
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    localparam logic [2:0] WAIT_INIT    = (MEM_LATENCY > 1) ? 3'(MEM_LATENCY - 2) : 3'd0;
    localparam logic [3:0] STARVE_MAX   = 4'(STARVE_LIMIT);

    state_t      state_q, state_d;
    logic [2:0]  wait_q, wait_d;
    logic [3:0]  starve_q, starve_d;
    logic        grant_dm_q, grant_dm_d;
    logic        wr_q, wr_d;
    logic        mem_enable_q, mem_enable_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic [11:0] mem_address_q, mem_address_d;
    logic [31:0] mem_in_q, mem_in_d;
    logic        im_ack_q, im_ack_d;
    logic        dm_ack_q, dm_ack_d;
    logic [31:0] im_rdata_q, im_rdata_d;
    logic [31:0] dm_rdata_q, dm_rdata_d;
    logic        perr_q, perr_d;
    logic        busy_q, busy_d;

    logic        dm_req;
    logic        pick_dm;

    assign dm_req  = dm_read | dm_write;
    assign pick_dm = dm_req && !(im_req && (starve_q == STARVE_MAX));

    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        starve_d      = starve_q;
        grant_dm_d    = grant_dm_q;
        wr_d          = wr_q;
        mem_enable_d  = 1'b0;
        mem_read_d    = 1'b0;
        mem_write_d   = 1'b0;
        mem_address_d = mem_address_q;
        mem_in_d      = mem_in_q;
        im_ack_d      = 1'b0;
        dm_ack_d      = 1'b0;
        im_rdata_d    = im_rdata_q;
        dm_rdata_d    = dm_rdata_q;
        perr_d        = perr_q;

        case (state_q)
            IDLE: begin
                if (dm_req || im_req) begin
                    state_d      = ISSUE;
                    mem_enable_d = 1'b1;
                    if (pick_dm) begin
                        grant_dm_d    = 1'b1;
                        starve_d      = im_req ? 4'(starve_q + 4'd1) : 4'd0;
                        wr_d          = dm_write;
                        mem_read_d    = !dm_write;
                        mem_write_d   = dm_write;
                        mem_address_d = dm_address;
                        if (dm_write) begin
                            mem_in_d = dm_wdata;
                        end
                        if (dm_read && dm_write) begin
                            perr_d = 1'b1;
                        end
                    end else begin
                        grant_dm_d    = 1'b0;
                        starve_d      = 4'd0;
                        wr_d          = 1'b0;
                        mem_read_d    = 1'b1;
                        mem_address_d = IM_BASE + {2'b00, im_address};
                    end
                end
            end
            ISSUE: begin
                if (MEM_LATENCY == 1) begin
                    state_d  = ACK;
                    im_ack_d = !grant_dm_q;
                    dm_ack_d = grant_dm_q;
                end else begin
                    state_d = WAIT;
                    wait_d  = WAIT_INIT;
                end
            end
            WAIT: begin
                if (wait_q == 3'd0) begin
                    state_d  = ACK;
                    im_ack_d = !grant_dm_q;
                    dm_ack_d = grant_dm_q;
                end else begin
                    wait_d = wait_q - 3'd1;
                end
            end
            ACK: begin
                state_d = IDLE;
                if (!grant_dm_q) begin
                    im_rdata_d = mem_out;
                end else if (!wr_q) begin
                    dm_rdata_d = mem_out;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            wait_q        <= 3'd0;
            starve_q      <= 4'd0;
            grant_dm_q    <= 1'b0;
            wr_q          <= 1'b0;
            mem_enable_q  <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_address_q <= 12'd0;
            mem_in_q      <= 32'd0;
            im_ack_q      <= 1'b0;
            dm_ack_q      <= 1'b0;
            im_rdata_q    <= 32'd0;
            dm_rdata_q    <= 32'd0;
            perr_q        <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_q        <= wait_d;
            starve_q      <= starve_d;
            grant_dm_q    <= grant_dm_d;
            wr_q          <= wr_d;
            mem_enable_q  <= mem_enable_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            mem_address_q <= mem_address_d;
            mem_in_q      <= mem_in_d;
            im_ack_q      <= im_ack_d;
            dm_ack_q      <= dm_ack_d;
            im_rdata_q    <= im_rdata_d;
            dm_rdata_q    <= dm_rdata_d;
            perr_q        <= perr_d;
            busy_q        <= busy_d;
        end
    end

    // mem_out only becomes valid in the ACK cycle itself, so rdata bypasses
    // the capture register during the ack pulse and holds the register after.
    assign im_rdata       = im_ack_q ? mem_out : im_rdata_q;
    assign dm_rdata       = (dm_ack_q && !wr_q) ? mem_out : dm_rdata_q;
    assign im_ack         = im_ack_q;
    assign dm_ack         = dm_ack_q;
    assign mem_enable     = mem_enable_q;
    assign mem_read       = mem_read_q;
    assign mem_write      = mem_write_q;
    assign mem_address    = mem_address_q;
    assign mem_in         = mem_in_q;
    assign busy           = busy_q;
    assign grant_dm       = grant_dm_q;
    assign protocol_error = perr_q;

endmodule
